clock_mode_ctrl: RTL

Mode controller and sequencer for the six-digit BCD clock datapath (hh:mm:ss counter chain, clock divider, seven-segment decoders). Decodes three debounced button pulses into a mode state machine and drives the divider mode select, the counter run enable and per-digit increment pulses. Also drives the stopwatch clear, the display blink mask, an internal BCD alarm register and the alarm ring output. Sits between the button front end and the counter/divider datapath; all outputs are registered.

---
 rtl/clock_mode_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/clock_mode_ctrl.sv
// Mode sequencer for the six-digit BCD clock: decodes button pulses into modes,
// drives divider select, counter enables/increments, blink mask and the alarm.
module clock_mode_ctrl #(
  parameter int RING_TICKS = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        btn_mode,
  input  logic        btn_next,
  input  logic        btn_inc,
  input  logic        alarm_valid,
  input  logic [23:0] cur_time,
  output logic [2:0]  mode,
  output logic [1:0]  clk_mod,
  output logic        count_en,
  output logic [5:0]  digit_inc,
  output logic        sw_clr,
  output logic [5:0]  blink_mask,
  output logic [15:0] alarm_time,
  output logic        alarm_ring
);

  typedef enum logic [2:0] {
    NOP       = 3'd0,
    TIMING    = 3'd1,
    ADJ_TIME  = 3'd2,
    ALARM_M   = 3'd3,
    STOPWATCH = 3'd4
  } mode_t;

  mode_t       r_mode, w_nextMode;
  logic [2:0]  r_ptr, w_nextPtr;
  logic        r_run, w_nextRun;
  logic [15:0] r_alarm, w_nextAlarm, w_incAlarm;
  logic        r_ring, w_nextRing;
  logic [5:0]  r_ringCnt, w_nextRingCnt;
  logic        r_countEn, w_nextCountEn;
  logic [1:0]  r_clkMod, w_nextClkMod;
  logic [5:0]  r_blink, w_nextBlink;
  logic [5:0]  r_digitInc, w_nextDigitInc;
  logic        r_swClr, w_nextSwClr;

  logic        w_dismiss;
  logic        w_alarmHit;
  logic [3:0]  w_ht, w_hu, w_mt, w_mu;
  logic [3:0]  w_htNew;

  assign w_dismiss  = r_ring & (btn_mode | btn_next | btn_inc);
  assign w_alarmHit = (cur_time[23:8] == r_alarm) && (cur_time[7:0] == 8'h00);

  // Alarm digit increment for the digit under the pointer; hr units is clamped
  // whenever the hr tens digit lands on 2.
  always_comb begin
    w_ht    = r_alarm[15:12];
    w_hu    = r_alarm[11:8];
    w_mt    = r_alarm[7:4];
    w_mu    = r_alarm[3:0];
    w_htNew = r_alarm[15:12];
    case (r_ptr)
      3'd2: w_mu = (r_alarm[3:0] >= 4'd9) ? 4'd0 : r_alarm[3:0] + 4'd1;
      3'd3: w_mt = (r_alarm[7:4] >= 4'd5) ? 4'd0 : r_alarm[7:4] + 4'd1;
      3'd4: begin
        if (r_alarm[15:12] == 4'd2)
          w_hu = (r_alarm[11:8] >= 4'd3) ? 4'd0 : r_alarm[11:8] + 4'd1;
        else
          w_hu = (r_alarm[11:8] >= 4'd9) ? 4'd0 : r_alarm[11:8] + 4'd1;
      end
      3'd5: begin
        w_htNew = (r_alarm[15:12] >= 4'd2) ? 4'd0 : r_alarm[15:12] + 4'd1;
        w_ht    = w_htNew;
        if (w_htNew == 4'd2 && r_alarm[11:8] > 4'd3)
          w_hu = 4'd3;
      end
      default: ;
    endcase
    w_incAlarm = {w_ht, w_hu, w_mt, w_mu};
  end

  // Next-state logic: ring dismissal swallows every button, otherwise the
  // highest-priority button pulse acts on the current mode.
  always_comb begin
    w_nextMode     = r_mode;
    w_nextPtr      = r_ptr;
    w_nextRun      = r_run;
    w_nextAlarm    = r_alarm;
    w_nextRing     = r_ring;
    w_nextRingCnt  = r_ringCnt;
    w_nextDigitInc = 6'd0;
    w_nextSwClr    = 1'b0;
    w_nextCountEn  = 1'b0;
    w_nextClkMod   = 2'd0;
    w_nextBlink    = 6'd0;

    if (!w_dismiss) begin
      if (btn_mode) begin
        case (r_mode)
          NOP:      w_nextMode = TIMING;
          TIMING: begin
            w_nextMode = ADJ_TIME;
            w_nextPtr  = 3'd0;
          end
          ADJ_TIME: begin
            w_nextMode = ALARM_M;
            w_nextPtr  = 3'd2;
          end
          ALARM_M: begin
            w_nextMode  = STOPWATCH;
            w_nextRun   = 1'b0;
            w_nextSwClr = 1'b1;
          end
          STOPWATCH: begin
            w_nextMode  = TIMING;
            w_nextRun   = 1'b0;
            w_nextSwClr = 1'b1;
          end
          default:  w_nextMode = NOP;
        endcase
      end else if (btn_next) begin
        case (r_mode)
          ADJ_TIME:  w_nextPtr   = (r_ptr >= 3'd5) ? 3'd0 : r_ptr + 3'd1;
          ALARM_M:   w_nextPtr   = (r_ptr >= 3'd5) ? 3'd2 : r_ptr + 3'd1;
          STOPWATCH: w_nextSwClr = ~r_run;
          default: ;
        endcase
      end else if (btn_inc) begin
        case (r_mode)
          ADJ_TIME:  w_nextDigitInc = 6'd1 << r_ptr;
          ALARM_M:   w_nextAlarm    = w_incAlarm;
          STOPWATCH: w_nextRun      = ~r_run;
          default: ;
        endcase
      end
    end

    if (!alarm_valid || r_mode != TIMING || w_nextMode != TIMING) begin
      w_nextRing = 1'b0;
    end else if (r_ring) begin
      if (w_dismiss) begin
        w_nextRing = 1'b0;
      end else if (tick) begin
        if (r_ringCnt == 6'(RING_TICKS - 1))
          w_nextRing = 1'b0;
        w_nextRingCnt = r_ringCnt + 6'd1;
      end
    end else if (tick && w_alarmHit) begin
      w_nextRing    = 1'b1;
      w_nextRingCnt = 6'd0;
    end

    w_nextCountEn = (w_nextMode == TIMING) || (w_nextMode == STOPWATCH && w_nextRun);
    if (w_nextMode == TIMING)
      w_nextClkMod = 2'd1;
    else if (w_nextMode == STOPWATCH)
      w_nextClkMod = 2'd2;
    if (w_nextMode == ADJ_TIME || w_nextMode == ALARM_M)
      w_nextBlink = 6'd1 << w_nextPtr;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mode     <= NOP;
      r_ptr      <= 3'd0;
      r_run      <= 1'b0;
      r_alarm    <= 16'h0000;
      r_ring     <= 1'b0;
      r_ringCnt  <= 6'd0;
      r_countEn  <= 1'b0;
      r_clkMod   <= 2'd0;
      r_blink    <= 6'd0;
      r_digitInc <= 6'd0;
      r_swClr    <= 1'b0;
    end else begin
      r_mode     <= w_nextMode;
      r_ptr      <= w_nextPtr;
      r_run      <= w_nextRun;
      r_alarm    <= w_nextAlarm;
      r_ring     <= w_nextRing;
      r_ringCnt  <= w_nextRingCnt;
      r_countEn  <= w_nextCountEn;
      r_clkMod   <= w_nextClkMod;
      r_blink    <= w_nextBlink;
      r_digitInc <= w_nextDigitInc;
      r_swClr    <= w_nextSwClr;
    end
  end

  assign mode       = r_mode;
  assign clk_mod    = r_clkMod;
  assign count_en   = r_countEn;
  assign digit_inc  = r_digitInc;
  assign sw_clr     = r_swClr;
  assign blink_mask = r_blink;
  assign alarm_time = r_alarm;
  assign alarm_ring = r_ring;

endmodule
